rob_multi_commit: RTL and testbench

Parametrised reorder buffer sitting between dispatch and the register file. It allocates tagged in-order entries and accepts out-of-order results on several completion channels. It retires up to COMMIT_WIDTH ready entries per cycle in program order. When a mispredicted branch retires, it flushes all younger entries.

---
 rtl/rob_multi_commit.sv | 128 ++++++++++++
 tb/tb_rob_multi_commit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order alloc, out-of-order completion, up to COMMIT_WIDTH in-order retires per cycle; ROB_FLUSH_EN builds mispredict flush.
// Latency: completion -> commit one cycle later; alloc -> commit at least two cycles; commit outputs are combinational from registered state.
// Backpressure: alloc_ack drops when full, in reset, or during a flush; completions to non-valid entries are dropped.
module rob_multi_commit #(
    parameter int WIDTH         = 32,
    parameter int SIZE          = 16,
    parameter int CPL_PORTS     = 3,
    parameter int COMMIT_WIDTH  = 2,
    localparam int TAG_W        = $clog2(SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alloc_req,
    input  logic [4:0]                    alloc_rd,
    output logic                          alloc_ack,
    output logic [TAG_W-1:0]              alloc_tag,
    input  logic [CPL_PORTS-1:0]          cpl_valid,
    input  logic [CPL_PORTS*TAG_W-1:0]    cpl_tag,
    input  logic [CPL_PORTS*WIDTH-1:0]    cpl_data,
    input  logic [CPL_PORTS-1:0]          cpl_mispredict,
    input  logic [CPL_PORTS*WIDTH-1:0]    cpl_target,
    output logic [COMMIT_WIDTH-1:0]       commit_valid,
    output logic [COMMIT_WIDTH*TAG_W-1:0] commit_tag,
    output logic [COMMIT_WIDTH*5-1:0]     commit_rd,
    output logic [COMMIT_WIDTH*WIDTH-1:0] commit_data,
    output logic                          flush,
    output logic [WIDTH-1:0]              flush_pc,
    output logic [TAG_W:0]                count,
    output logic                          full,
    output logic                          empty
);

    localparam logic [TAG_W:0] SIZE_C = (TAG_W+1)'(SIZE);
    localparam logic [TAG_W:0] ONE_C  = (TAG_W+1)'(1);

    logic [SIZE-1:0]  ent_valid;
    logic [SIZE-1:0]  ent_rdy;
    logic [4:0]       ent_rd   [SIZE];
    logic [WIDTH-1:0] ent_data [SIZE];
`ifdef ROB_FLUSH_EN
    logic [SIZE-1:0]  ent_misp;
    logic [WIDTH-1:0] ent_target [SIZE];
`else
    logic unused_cpl;
    assign unused_cpl = ^{cpl_mispredict, cpl_target};
`endif

    logic [TAG_W:0]   head, tail;
    logic [TAG_W:0]   n_commit;
    logic [TAG_W-1:0] lane_idx [COMMIT_WIDTH];
    logic             stop;
    logic             flush_c;
    logic [WIDTH-1:0] flush_pc_c;

    // The wrap bit in head/tail distinguishes full from empty when the indices match.
    assign count     = tail - head;
    assign full      = (count == SIZE_C);
    assign empty     = (count == '0);
    assign alloc_tag = tail[TAG_W-1:0];
    assign alloc_ack = alloc_req & ~full & ~flush_c & ~rst;
    assign flush     = flush_c;
    assign flush_pc  = flush_pc_c;

    // Walk lanes oldest-first; the first unready entry (or a mispredict) ends the group.
    always_comb begin
        commit_valid = '0;
        commit_tag   = '0;
        commit_rd    = '0;
        commit_data  = '0;
        n_commit     = '0;
        flush_c      = 1'b0;
        flush_pc_c   = '0;
        stop         = rst;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            lane_idx[k] = head[TAG_W-1:0] + TAG_W'(k);
            if (!stop && ent_valid[lane_idx[k]] && ent_rdy[lane_idx[k]]) begin
                commit_valid[k]               = 1'b1;
                commit_tag[k*TAG_W +: TAG_W]  = lane_idx[k];
                commit_rd[k*5 +: 5]           = ent_rd[lane_idx[k]];
                commit_data[k*WIDTH +: WIDTH] = ent_data[lane_idx[k]];
                n_commit                      = n_commit + ONE_C;
`ifdef ROB_FLUSH_EN
                if (ent_misp[lane_idx[k]]) begin
                    flush_c    = 1'b1;
                    flush_pc_c = ent_target[lane_idx[k]];
                    stop       = 1'b1;
                end
`endif
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_c) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (commit_valid[k]) ent_valid[lane_idx[k]] <= 1'b0;
            end
            head <= head + n_commit;
            if (alloc_ack) begin
                ent_valid[tail[TAG_W-1:0]] <= 1'b1;
                ent_rdy[tail[TAG_W-1:0]]   <= 1'b0;
                ent_rd[tail[TAG_W-1:0]]    <= alloc_rd;
`ifdef ROB_FLUSH_EN
                ent_misp[tail[TAG_W-1:0]]  <= 1'b0;
`endif
                tail <= tail + ONE_C;
            end
            // Later channels overwrite earlier ones on a shared tag.
            for (int i = 0; i < CPL_PORTS; i++) begin
                if (cpl_valid[i] && ent_valid[cpl_tag[i*TAG_W +: TAG_W]]) begin
                    ent_rdy[cpl_tag[i*TAG_W +: TAG_W]]  <= 1'b1;
                    ent_data[cpl_tag[i*TAG_W +: TAG_W]] <= cpl_data[i*WIDTH +: WIDTH];
`ifdef ROB_FLUSH_EN
                    ent_misp[cpl_tag[i*TAG_W +: TAG_W]]   <= cpl_mispredict[i];
                    ent_target[cpl_tag[i*TAG_W +: TAG_W]] <= cpl_target[i*WIDTH +: WIDTH];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit with SIZE=4, COMMIT_WIDTH=2, three completion channels.
module tb_rob_multi_commit;
    localparam int WIDTH = 32;
    localparam int SIZE  = 4;
    localparam int CP    = 3;
    localparam int CW    = 2;
    localparam int TW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_req;
    logic [4:0]        alloc_rd;
    logic              alloc_ack;
    logic [TW-1:0]     alloc_tag;
    logic [CP-1:0]     cpl_valid;
    logic [CP*TW-1:0]  cpl_tag;
    logic [CP*WIDTH-1:0] cpl_data;
    logic [CP-1:0]     cpl_mispredict;
    logic [CP*WIDTH-1:0] cpl_target;
    logic [CW-1:0]     commit_valid;
    logic [CW*TW-1:0]  commit_tag;
    logic [CW*5-1:0]   commit_rd;
    logic [CW*WIDTH-1:0] commit_data;
    logic              flush;
    logic [WIDTH-1:0]  flush_pc;
    logic [TW:0]       count;
    logic              full;
    logic              empty;

    int checks = 0;
    int errors = 0;
    int exp_tags [6] = '{0, 1, 2, 3, 0, 1};
    int head_tag;
    int n_alloc;

    rob_multi_commit #(.WIDTH(WIDTH), .SIZE(SIZE), .CPL_PORTS(CP), .COMMIT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_ack(alloc_ack), .alloc_tag(alloc_tag),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
        .cpl_mispredict(cpl_mispredict), .cpl_target(cpl_target),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_data(commit_data), .flush(flush), .flush_pc(flush_pc),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cpl(input int ch, input int tag, input logic [31:0] data,
                           input logic misp, input logic [31:0] tgt);
        cpl_valid[ch]              = 1'b1;
        cpl_tag[ch*TW +: TW]       = TW'(tag);
        cpl_data[ch*WIDTH +: WIDTH]   = data;
        cpl_mispredict[ch]         = misp;
        cpl_target[ch*WIDTH +: WIDTH] = tgt;
    endtask

    task automatic clear_cpl();
        cpl_valid      = '0;
        cpl_tag        = '0;
        cpl_data       = '0;
        cpl_mispredict = '0;
        cpl_target     = '0;
    endtask

    initial begin
        rst = 1'b1;
        alloc_req = 1'b0;
        alloc_rd = '0;
        clear_cpl();
        tick();
        alloc_req = 1'b1;
        #1;
        chk("rst_alloc_ack", alloc_ack, 0);
        chk("rst_commit_valid", commit_valid, 0);
        tick();

        // Reset state
        rst = 1'b0;
        alloc_req = 1'b0;
        #1;
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_commit_valid", commit_valid, 0);
        chk("reset_flush", flush, 0);
        chk("reset_flush_pc", flush_pc, 0);
        chk("reset_alloc_tag", alloc_tag, 0);
        chk("reset_alloc_ack", alloc_ack, 0);

        // Fill: tags 0..3, then refused
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1;
            alloc_rd = 5'(i + 1);
            #1;
            chk("fill_ack", alloc_ack, 1);
            chk("fill_tag", alloc_tag, i);
            tick();
        end
        #1;
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        chk("fill_refused", alloc_ack, 0);
        alloc_req = 1'b0;

        // Tags 1 and 0 complete together on different channels
        set_cpl(0, 1, 32'h11, 1'b0, 32'h0);
        set_cpl(2, 0, 32'h10, 1'b0, 32'h0);
        #1;
        chk("cpl_not_same_cycle", commit_valid, 0);
        tick();
        clear_cpl();
        #1;
        chk("dual_valid", commit_valid, 2'b11);
        chk("dual_tag", commit_tag, 4'h4);
        chk("dual_rd", commit_rd, 10'h041);
        chk("dual_data", commit_data, 64'h00000011_00000010);
        chk("dual_count_before", count, 4);
        tick();
        chk("dual_count_after", count, 2);
        chk("dual_idle", commit_valid, 0);

        // Younger ready, head unready: nothing retires
        set_cpl(1, 3, 32'h33, 1'b0, 32'h0);
        tick();
        clear_cpl();
        #1;
        chk("blocked_head", commit_valid, 0);
        set_cpl(0, 2, 32'h22, 1'b0, 32'h0);
        tick();
        clear_cpl();
        #1;
        chk("unblock_valid", commit_valid, 2'b11);
        chk("unblock_tag", commit_tag, 4'hE);
        chk("unblock_rd", commit_rd, 10'h083);
        chk("unblock_data", commit_data, 64'h00000033_00000022);
        tick();
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // Completion to an empty slot is dropped
        set_cpl(0, 0, 32'hDEAD, 1'b0, 32'h0);
        tick();
        clear_cpl();
        #1;
        chk("drop_commit", commit_valid, 0);
        chk("drop_empty", empty, 1);

        // Six single-entry rounds across the wrap
        for (int r = 0; r < 6; r++) begin
            alloc_req = 1'b1;
            alloc_rd = 5'(r + 8);
            #1;
            chk("wrap_empty_pre", empty, 1);
            chk("wrap_ack", alloc_ack, 1);
            chk("wrap_tag", alloc_tag, exp_tags[r]);
            tick();
            alloc_req = 1'b0;
            chk("wrap_count", count, 1);
            chk("wrap_not_empty", empty, 0);
            chk("wrap_not_full", full, 0);
            set_cpl(1, exp_tags[r], 32'hA0 + 32'(r), 1'b0, 32'h0);
            tick();
            clear_cpl();
            #1;
            chk("wrap_commit", commit_valid, 2'b01);
            chk("wrap_commit_tag", commit_tag[TW-1:0], exp_tags[r]);
            chk("wrap_commit_data", commit_data[WIDTH-1:0], 32'hA0 + 32'(r));
            tick();
        end
        chk("wrap_end_empty", empty, 1);

        // Full with a head-only commit: allocation refused
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1;
            alloc_rd = 5'(16 + i);
            #1;
            chk("refill_tag", alloc_tag, exp_tags[(i + 2) % 4]);
            tick();
        end
        alloc_req = 1'b0;
        #1;
        chk("refill_full", full, 1);
        set_cpl(2, 2, 32'h200, 1'b0, 32'h0);
        tick();
        clear_cpl();
        alloc_req = 1'b1;
        #1;
        chk("full_commit_lane0", commit_valid, 2'b01);
        chk("full_commit_tag", commit_tag[TW-1:0], 2);
        chk("full_alloc_refused", alloc_ack, 0);
        tick();
        alloc_req = 1'b0;
        chk("after_full_count", count, 3);
        chk("after_full_not_full", full, 0);

        // SIZE-1 with a commit: allocation granted
        set_cpl(0, 3, 32'h300, 1'b0, 32'h0);
        tick();
        clear_cpl();
        alloc_req = 1'b1;
        alloc_rd = 5'd20;
        #1;
        chk("sm1_commit", commit_valid, 2'b01);
        chk("sm1_alloc_ack", alloc_ack, 1);
        chk("sm1_alloc_tag", alloc_tag, 2);
        tick();
        alloc_req = 1'b0;
        chk("sm1_count", count, 3);

        // Tag 1 resolves mispredicted to 0x100
        set_cpl(0, 0, 32'h400, 1'b0, 32'h0);
        set_cpl(1, 1, 32'h401, 1'b1, 32'h0000_0100);
        tick();
        clear_cpl();
        alloc_req = 1'b1;
        #1;
        chk("misp_commit", commit_valid, 2'b11);
        chk("misp_data", commit_data, 64'h00000401_00000400);
`ifdef ROB_FLUSH_EN
        chk("misp_flush", flush, 1);
        chk("misp_flush_pc", flush_pc, 32'h100);
        chk("misp_alloc_blocked", alloc_ack, 0);
        tick();
        alloc_req = 1'b0;
        chk("post_flush_empty", empty, 1);
        chk("post_flush_count", count, 0);
        chk("post_flush_tag", alloc_tag, 0);
        chk("post_flush_idle", flush, 0);
        n_alloc = 3;
        head_tag = 0;
`else
        chk("noflush_flush", flush, 0);
        chk("noflush_flush_pc", flush_pc, 0);
        chk("noflush_alloc_ack", alloc_ack, 1);
        chk("noflush_alloc_tag", alloc_tag, 3);
        tick();
        alloc_req = 1'b0;
        chk("noflush_count", count, 2);
        n_alloc = 1;
        head_tag = 2;
`endif

        // Mid-operation reset with three live entries and a ready head
        for (int i = 0; i < n_alloc; i++) begin
            alloc_req = 1'b1;
            alloc_rd = 5'(24 + i);
            tick();
        end
        alloc_req = 1'b0;
        #1;
        chk("prerst_count", count, 3);
        set_cpl(0, head_tag, 32'h55, 1'b0, 32'h0);
        tick();
        clear_cpl();
        rst = 1'b1;
        alloc_req = 1'b1;
        set_cpl(1, (head_tag + 1) % 4, 32'h66, 1'b0, 32'h0);
        set_cpl(2, (head_tag + 2) % 4, 32'h77, 1'b0, 32'h0);
        #1;
        chk("rst_mid_no_commit", commit_valid, 0);
        chk("rst_mid_no_ack", alloc_ack, 0);
        tick();
        rst = 1'b0;
        alloc_req = 1'b0;
        clear_cpl();
        #1;
        chk("rst_after_count", count, 0);
        chk("rst_after_commit", commit_valid, 0);
        chk("rst_after_tag", alloc_tag, 0);
        chk("rst_after_empty", empty, 1);
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        chk("rst_realloc_count", count, 1);
        chk("rst_realloc_unready", commit_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
